// File: rtl/idelay_pkg.sv
// Shared types and constants for the IDELAYE2 tap loader.
package idelay_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StPipe,
    StLoad,
    StSettle,
    StCheck
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_RDYLOST  = 2'd3;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/idelay_tap_loader_if.sv
// Request/status bundle between a delay requester and the tap loader.
interface idelay_tap_loader_if #(
  parameter int unsigned TAP_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [TAP_W-1:0] req_tap;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [TAP_W-1:0] cur_tap;

  modport master (
    output req_valid, req_tap,
    input  req_ready, busy, done, err, err_code, cur_tap
  );

  modport slave (
    input  req_valid, req_tap,
    output req_ready, busy, done, err, err_code, cur_tap
  );
endinterface

// File: rtl/tap_cycle_cnt.sv
// Clear/enable cycle counter with a terminal-compare flag.
module tap_cycle_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);
endmodule

// File: rtl/idelay_tap_loader.sv
// Loads a requested tap into an IDELAYE2 (VAR_LOAD/PIPE_SEL) and confirms it by readback.
module idelay_tap_loader
  import idelay_pkg::*;
#(
  parameter int unsigned TAP_W       = 5,
  parameter int unsigned MAX_TAP     = 31,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned RDY_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rstn,
  idelay_tap_loader_if.slave  req,
  input  logic                dly_rdy,
  input  logic [TAP_W-1:0]    cntvalueout,
  output logic [TAP_W-1:0]    cntvaluein,
  output logic                ldpipeen,
  output logic                ld
);
  localparam logic [TAP_W-1:0] MaxTap = TAP_W'(MAX_TAP);

  state_e           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] cur_q, cur_d;
  logic [1:0]       code_q, code_d;
  logic [TAP_W-1:0] sat_tap;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_lim;

  assign sat_tap = (req.req_tap > MaxTap) ? MaxTap : req.req_tap;

  // Counter starts at zero on entry, so the terminal value is (cycles - 1) for SETTLE;
  // WAIT_RDY gives up after RDY_TIMEOUT + 1 cycles spent waiting.
  assign cnt_lim = (state_q == StWaitRdy) ? CNT_W'(RDY_TIMEOUT) : CNT_W'(SETTLE_CYC - 1);

  tap_cycle_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .limit_i(cnt_lim),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    cur_d   = cur_q;
    code_d  = code_q;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req.req_valid) begin
          tap_d   = sat_tap;
          code_d  = ERR_NONE;
          state_d = StWaitRdy;
        end
      end
      StWaitRdy: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (dly_rdy) begin
          state_d = StPipe;
        end else if (cnt_tc) begin
          code_d  = ERR_TIMEOUT;
          state_d = StCheck;
        end
      end
      StPipe: begin
        if (!dly_rdy) begin
          code_d  = ERR_RDYLOST;
          state_d = StCheck;
        end else begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!dly_rdy) begin
          code_d  = ERR_RDYLOST;
          state_d = StCheck;
        end else begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (!dly_rdy) begin
          code_d  = ERR_RDYLOST;
          state_d = StCheck;
        end else if (cnt_tc) begin
          // Readback is sampled on the last settle cycle so err/err_code come from flops.
          if (cntvalueout != tap_q) begin
            code_d = ERR_MISMATCH;
          end
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (code_q == ERR_NONE) begin
          cur_d = tap_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      tap_q   <= '0;
      cur_q   <= '0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      cur_q   <= cur_d;
      code_q  <= code_d;
    end
  end

  assign req.req_ready = (state_q == StIdle);
  assign req.busy      = (state_q != StIdle);
  assign req.done      = (state_q == StCheck);
  assign req.err       = (state_q == StCheck) && (code_q != ERR_NONE);
  assign req.err_code  = code_q;
  assign req.cur_tap   = cur_q;
  assign cntvaluein    = tap_q;
  assign ldpipeen      = (state_q == StPipe);
  assign ld            = (state_q == StLoad);
endmodule

// File: tb/tb_idelay_tap_loader.sv
// Randomized/directed bench for idelay_tap_loader with a behavioural IDELAYE2 model.
module tb_idelay_tap_loader;
  localparam int unsigned TW  = 6;
  localparam int unsigned MT  = 31;
  localparam int unsigned SC  = 8;
  localparam int unsigned RT  = 15;
  localparam int          LAT = SC + 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          dly_rdy = 1'b1;
  logic [TW-1:0] cntvalueout, cntvaluein;
  logic          ldpipeen, ld;
  logic [TW-1:0] model_reg = '0;
  logic [TW-1:0] corrupt = '0;
  logic [TW-1:0] exp_cur = '0;
  int            checks = 0;
  int            errors = 0;

  idelay_tap_loader_if #(.TAP_W(TW)) bus ();

  idelay_tap_loader #(
    .TAP_W      (TW),
    .MAX_TAP    (MT),
    .SETTLE_CYC (SC),
    .RDY_TIMEOUT(RT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (bus),
    .dly_rdy    (dly_rdy),
    .cntvalueout(cntvalueout),
    .cntvaluein (cntvaluein),
    .ldpipeen   (ldpipeen),
    .ld         (ld)
  );

  always #5 clk = ~clk;

  // IDELAYE2 stand-in: LD copies CNTVALUEIN into the tap, optionally corrupted.
  always @(posedge clk) if (ld) model_reg <= cntvaluein ^ corrupt;
  assign cntvalueout = model_reg;

  function automatic logic [TW-1:0] sat_of(input int unsigned t);
    if (t > MT) return TW'(MT);
    return TW'(t);
  endfunction

  task automatic issue(input logic [TW-1:0] tap, output logic rdy_seen);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_tap   = tap;
    @(negedge clk);
    rdy_seen = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic watch(input int bound, output int pipe_at, output int ld_at,
                       output int done_at, output int ld_cnt, output logic e,
                       output logic [1:0] c);
    pipe_at = -1; ld_at = -1; done_at = -1; ld_cnt = 0; e = 1'bx; c = 2'bxx;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (ldpipeen && pipe_at < 0) pipe_at = k;
      if (ld) begin
        ld_cnt++;
        if (ld_at < 0) ld_at = k;
      end
      if (bus.done) begin
        done_at = k;
        e = bus.err;
        c = bus.err_code;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ld !== 1'b0 || ldpipeen !== 1'b0) begin
      errors++; $display("FAIL rst_ld got ld=%b ldpipeen=%b want 0 0", ld, ldpipeen); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL rst_status got busy=%b done=%b err=%b want 0 0 0",
                         bus.busy, bus.done, bus.err); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_req_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.err_code !== 2'd0) begin
      errors++; $display("FAIL rst_err_code got %0d want 0", bus.err_code); end
    checks++; if (cntvaluein !== '0 || bus.cur_tap !== '0) begin
      errors++; $display("FAIL rst_taps got cntvaluein=%0d cur_tap=%0d want 0 0",
                         cntvaluein, bus.cur_tap); end
  endtask

  task automatic test_nominal();
    int pa, la, da, lc; logic e, rs; logic [1:0] c;
    issue(TW'(13), rs);
    checks++; if (rs !== 1'b1) begin
      errors++; $display("FAIL nom_accept_ready got %b want 1", rs); end
    watch(40, pa, la, da, lc, e, c);
    checks++; if (pa != 2) begin errors++; $display("FAIL nom_ldpipeen_at got %0d want 2", pa); end
    checks++; if (la != 3 || lc != 1) begin
      errors++; $display("FAIL nom_ld got at=%0d count=%0d want 3 1", la, lc); end
    checks++; if (da != LAT) begin errors++; $display("FAIL nom_done_at got %0d want %0d", da, LAT); end
    checks++; if (e !== 1'b0 || c !== 2'd0) begin
      errors++; $display("FAIL nom_err got err=%b code=%0d want 0 0", e, c); end
    @(negedge clk);
    exp_cur = TW'(13);
    checks++; if (bus.req_ready !== 1'b1 || bus.cur_tap !== exp_cur) begin
      errors++; $display("FAIL nom_after got ready=%b cur_tap=%0d want 1 %0d",
                         bus.req_ready, bus.cur_tap, exp_cur); end
  endtask

  task automatic test_saturate();
    int pa, la, da, lc; logic e, rs; logic [1:0] c;
    issue(TW'(40), rs);
    checks++; if (cntvaluein !== TW'(MT)) begin
      errors++; $display("FAIL sat_cntvaluein got %0d want %0d", cntvaluein, MT); end
    watch(40, pa, la, da, lc, e, c);
    checks++; if (da != LAT || e !== 1'b0) begin
      errors++; $display("FAIL sat_done got at=%0d err=%b want %0d 0", da, e, LAT); end
    @(negedge clk);
    exp_cur = TW'(MT);
    checks++; if (bus.cur_tap !== exp_cur) begin
      errors++; $display("FAIL sat_cur_tap got %0d want %0d", bus.cur_tap, exp_cur); end
  endtask

  task automatic test_mismatch();
    int pa, la, da, lc; logic e, rs; logic [1:0] c;
    corrupt = TW'(1);
    issue(TW'(13), rs);
    watch(40, pa, la, da, lc, e, c);
    checks++; if (da != LAT) begin errors++; $display("FAIL mis_done_at got %0d want %0d", da, LAT); end
    checks++; if (e !== 1'b1 || c !== 2'd1) begin
      errors++; $display("FAIL mis_err got err=%b code=%0d want 1 1", e, c); end
    repeat (3) @(negedge clk);
    checks++; if (bus.cur_tap !== exp_cur || bus.err_code !== 2'd1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL mis_hold got cur_tap=%0d code=%0d err=%b want %0d 1 0",
                         bus.cur_tap, bus.err_code, bus.err, exp_cur); end
    corrupt = '0;
  endtask

  task automatic test_timeout();
    int pa, la, da, lc; logic e, rs; logic [1:0] c;
    dly_rdy = 1'b0;
    issue(TW'(9), rs);
    watch(60, pa, la, da, lc, e, c);
    checks++; if (da != int'(RT) + 2) begin
      errors++; $display("FAIL tmo_done_at got %0d want %0d", da, RT + 2); end
    checks++; if (lc != 0 || pa != -1) begin
      errors++; $display("FAIL tmo_no_load got ld=%0d pipe_at=%0d want 0 -1", lc, pa); end
    checks++; if (e !== 1'b1 || c !== 2'd2) begin
      errors++; $display("FAIL tmo_err got err=%b code=%0d want 1 2", e, c); end
    dly_rdy = 1'b1;
    @(negedge clk);
    checks++; if (bus.cur_tap !== exp_cur) begin
      errors++; $display("FAIL tmo_cur_tap got %0d want %0d", bus.cur_tap, exp_cur); end
  endtask

  task automatic test_rdy_lost();
    logic rs;
    issue(TW'(5), rs);
    repeat (4) @(posedge clk);
    #1 bus.req_valid = 1'b1;
    bus.req_tap = TW'(22);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    dly_rdy = 1'b0;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL lost_settle got done=%b busy=%b want 0 1", bus.done, bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.err_code !== 2'd3) begin
      errors++; $display("FAIL lost_check got done=%b err=%b code=%0d want 1 1 3",
                         bus.done, bus.err, bus.err_code); end
    dly_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.cur_tap !== exp_cur || bus.err_code !== 2'd3) begin
        errors++; $display("FAIL lost_after got busy=%b cur_tap=%0d code=%0d want 0 %0d 3",
                           bus.busy, bus.cur_tap, bus.err_code, exp_cur); end
    end
  endtask

  task automatic test_reset_mid();
    int pa, la, da, lc; logic e, rs; logic [1:0] c;
    issue(TW'(20), rs);
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++; if (ld !== 1'b1) begin errors++; $display("FAIL rmid_in_load got ld=%b want 1", ld); end
    rstn = 1'b0;
    #1;
    checks++; if (ld !== 1'b0 || ldpipeen !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_outputs got ld=%b pipe=%b busy=%b ready=%b want 0 0 0 1",
                         ld, ldpipeen, bus.busy, bus.req_ready); end
    checks++; if (cntvaluein !== '0 || bus.cur_tap !== '0 || bus.err_code !== 2'd0) begin
      errors++; $display("FAIL rmid_regs got cntvaluein=%0d cur_tap=%0d code=%0d want 0 0 0",
                         cntvaluein, bus.cur_tap, bus.err_code); end
    exp_cur = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    issue(TW'(7), rs);
    watch(40, pa, la, da, lc, e, c);
    checks++; if (da != LAT || e !== 1'b0 || la != 3) begin
      errors++; $display("FAIL rmid_next got done_at=%0d err=%b ld_at=%0d want %0d 0 3",
                         da, e, la, LAT); end
    @(negedge clk);
    exp_cur = TW'(7);
    checks++; if (bus.cur_tap !== exp_cur) begin
      errors++; $display("FAIL rmid_cur_tap got %0d want %0d", bus.cur_tap, exp_cur); end
  endtask

  task automatic test_back_to_back_random();
    int pa, la, da, lc; logic e, rs; logic [1:0] c;
    int unsigned t; logic [TW-1:0] m, s; logic [1:0] exp_code;
    for (int i = 0; i < 24; i++) begin
      t = $urandom_range(0, 63);
      m = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(1, 63)) : '0;
      s = sat_of(t);
      exp_code = ((s ^ m) != s) ? 2'd1 : 2'd0;
      corrupt = m;
      issue(TW'(t), rs);
      checks++; if (rs !== 1'b1 || cntvaluein !== s || bus.cur_tap !== exp_cur) begin
        errors++; $display("FAIL rnd%0d_accept got ready=%b cntvaluein=%0d cur_tap=%0d want 1 %0d %0d",
                           i, rs, cntvaluein, bus.cur_tap, s, exp_cur); end
      watch(40, pa, la, da, lc, e, c);
      checks++; if (da != LAT || e !== (exp_code != 0) || c !== exp_code) begin
        errors++; $display("FAIL rnd%0d_done got at=%0d err=%b code=%0d want %0d %b %0d",
                           i, da, e, c, LAT, exp_code != 0, exp_code); end
      if (exp_code == 2'd0) exp_cur = s;
    end
    corrupt = '0;
    @(negedge clk);
    checks++; if (bus.cur_tap !== exp_cur) begin
      errors++; $display("FAIL rnd_final_cur_tap got %0d want %0d", bus.cur_tap, exp_cur); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_tap   = '0;
    test_reset();
    test_nominal();
    test_saturate();
    test_mismatch();
    test_timeout();
    test_rdy_lost();
    test_reset_mid();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
